// File: rtl/diferential_muxpga_seq.sv
// ---------------------------------------------------------------------------
// diferential_muxpga_seq
//
// Host-side sequencer for the 4x3 mux-FPGA fabric. A job does four things:
// it clears the fabric, streams a configuration bitstream into it over a
// valid/ready handshake, runs the fabric for a programmed number of
// evaluation edges, and then captures the 8-bit fabric output. The captured
// result is held for the requester until it is acknowledged.
//
// Optional feature (compile-time macro): DIFERENTIAL_SEQ_VERIFY_EN
//   When defined, a VERIFY state follows LOAD. During VERIFY the chain is
//   recirculated for CFG_NIBBLES shifts (fabric tail nibble fed back into its
//   head), so the configuration ends up unchanged. The recirculated nibbles
//   are XOR-compared against a checksum of the loaded nibbles. A mismatch
//   sets err, which stays set until the next accepted start.
//   When the macro is undefined there is no VERIFY state and err is tied low.
//
// Parameters:
//   CFG_NIBBLES  - configuration nibbles per bitstream (2 per cell, 12 cells)
//   RUN_W        - width of the run-length count
//   CLEAR_CYCLES - cycles the fabric reset is held at job start (>=1)
//
// Ports:
//   clk          in   clock (the fabric shares this clock)
//   reset_n      in   asynchronous active-low reset
//   start        in   pulse that begins a job; only sampled in IDLE
//   run_len      in   evaluation edges to run; latched on an accepted start
//   run_data     in   nibble driven to the fabric during RUN/READ; latched on start
//   cfg_valid    in   host presents a configuration nibble
//   cfg_nibble   in   configuration nibble (the first one ends up deepest)
//   cfg_ready    out  sequencer accepts a nibble this cycle (LOAD only)
//   busy         out  high in every state except IDLE
//   result_valid out  result holds a captured fabric output
//   result       out  captured fabric output
//   result_ack   in   host consumed the result
//   err          out  configuration verify mismatch (optional feature)
//   fpga_reset   out  fabric synchronous active-high reset
//   fpga_cmd     out  fabric command: 0=shift, 1=run/read, 3=hold
//   fpga_nibble  out  fabric nibble_in
//   fpga_out     in   fabric io_out
// ---------------------------------------------------------------------------
module diferential_muxpga_seq #(
  parameter int CFG_NIBBLES  = 24,
  parameter int RUN_W        = 8,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [RUN_W-1:0] run_len,
  input  logic [3:0]       run_data,
  input  logic             cfg_valid,
  input  logic [3:0]       cfg_nibble,
  output logic             cfg_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [7:0]       result,
  input  logic             result_ack,
  output logic             err,
  output logic             fpga_reset,
  output logic [1:0]       fpga_cmd,
  output logic [3:0]       fpga_nibble,
  input  logic [7:0]       fpga_out
);

  localparam int NIB_W = (CFG_NIBBLES  > 1) ? $clog2(CFG_NIBBLES)  : 1;
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(CFG_NIBBLES - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  localparam logic [1:0] CMD_SHIFT = 2'd0;
  localparam logic [1:0] CMD_RUN   = 2'd1;
  localparam logic [1:0] CMD_HOLD  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
`ifdef DIFERENTIAL_SEQ_VERIFY_EN
    S_VERIFY,
`endif
    S_RUN,
    S_READ,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CLR_W-1:0] r_clrCnt;
  logic [NIB_W-1:0] r_nibCnt;
  logic [RUN_W-1:0] r_runCnt;
  logic [3:0]       r_runData;
  logic [7:0]       r_result;

  // Where a finished bitstream goes next. A zero run length skips RUN
  // entirely, so READ samples the freshly configured fabric.
  state_t w_afterCfg;
  assign w_afterCfg = (r_runCnt == '0) ? S_READ : S_RUN;

`ifdef DIFERENTIAL_SEQ_VERIFY_EN
  logic [3:0] r_cfgSum;
  logic [3:0] r_verSum;
  logic       r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign result = r_result;

  // State register. It is kept apart from the datapath so the FSM reads as
  // the usual register/next-state pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and the state-decoded control outputs. fpga_cmd is
  // combinational from state, except in LOAD, where it follows cfg_valid:
  // an idle host cycle has to hold the chain instead of shifting garbage in.
  // fpga_reset is also forced high while reset_n is low, so the fabric sits
  // in reset alongside the sequencer.
  always_comb begin
    w_next       = r_state;
    cfg_ready    = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    fpga_reset   = !reset_n;
    fpga_cmd     = CMD_HOLD;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        fpga_reset = 1'b1;
        if (r_clrCnt == CLR_LAST) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          fpga_cmd = CMD_SHIFT;
          if (r_nibCnt == NIB_LAST) begin
`ifdef DIFERENTIAL_SEQ_VERIFY_EN
            w_next = S_VERIFY;
`else
            w_next = w_afterCfg;
`endif
          end
        end
      end
`ifdef DIFERENTIAL_SEQ_VERIFY_EN
      S_VERIFY: begin
        fpga_cmd = CMD_SHIFT;
        if (r_nibCnt == NIB_LAST) begin
          w_next = w_afterCfg;
        end
      end
`endif
      S_RUN: begin
        fpga_cmd = CMD_RUN;
        if (r_runCnt <= RUN_W'(1)) begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        fpga_cmd = CMD_RUN;
        w_next   = S_DONE;
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (result_ack) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Fabric nibble mux. It is kept separate from the block above because in
  // VERIFY it depends on fpga_out, and fpga_out may in turn depend on
  // fpga_cmd combinationally inside the fabric.
  always_comb begin
    fpga_nibble = 4'h0;
    case (r_state)
      S_LOAD: begin
        if (cfg_valid) begin
          fpga_nibble = cfg_nibble;
        end
      end
`ifdef DIFERENTIAL_SEQ_VERIFY_EN
      S_VERIFY: begin
        fpga_nibble = fpga_out[7:4];
      end
`endif
      S_RUN, S_READ: begin
        fpga_nibble = r_runData;
      end
      default: begin
        fpga_nibble = 4'h0;
      end
    endcase
  end

  // Job datapath: the CLEAR/LOAD/VERIFY counters, the run-length down
  // counter, latched job parameters and the captured result. Each counter
  // returns to zero on the edge that leaves its state, so every job starts
  // from a clean count. The result is only written in READ, which means it
  // survives DONE and IDLE until the next capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clrCnt  <= '0;
      r_nibCnt  <= '0;
      r_runCnt  <= '0;
      r_runData <= 4'h0;
      r_result  <= 8'h00;
`ifdef DIFERENTIAL_SEQ_VERIFY_EN
      r_cfgSum  <= 4'h0;
      r_verSum  <= 4'h0;
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_runCnt  <= run_len;
            r_runData <= run_data;
            r_clrCnt  <= '0;
            r_nibCnt  <= '0;
`ifdef DIFERENTIAL_SEQ_VERIFY_EN
            r_cfgSum  <= 4'h0;
            r_verSum  <= 4'h0;
            r_err     <= 1'b0;
`endif
          end
        end
        S_CLEAR: begin
          if (r_clrCnt == CLR_LAST) begin
            r_clrCnt <= '0;
          end else begin
            r_clrCnt <= r_clrCnt + CLR_W'(1);
          end
        end
        S_LOAD: begin
          if (cfg_valid) begin
            if (r_nibCnt == NIB_LAST) begin
              r_nibCnt <= '0;
            end else begin
              r_nibCnt <= r_nibCnt + NIB_W'(1);
            end
`ifdef DIFERENTIAL_SEQ_VERIFY_EN
            r_cfgSum <= r_cfgSum ^ cfg_nibble;
`endif
          end
        end
`ifdef DIFERENTIAL_SEQ_VERIFY_EN
        // The last recirculated nibble is folded in combinationally so the
        // comparison sees the complete checksum on the exiting edge.
        S_VERIFY: begin
          r_verSum <= r_verSum ^ fpga_out[7:4];
          if (r_nibCnt == NIB_LAST) begin
            r_nibCnt <= '0;
            if ((r_verSum ^ fpga_out[7:4]) != r_cfgSum) begin
              r_err <= 1'b1;
            end
          end else begin
            r_nibCnt <= r_nibCnt + NIB_W'(1);
          end
        end
`endif
        S_RUN: begin
          if (r_runCnt != '0) begin
            r_runCnt <= r_runCnt - RUN_W'(1);
          end
        end
        S_READ: begin
          r_result <= fpga_out;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_diferential_muxpga_seq.sv
// ---------------------------------------------------------------------------
// tb_diferential_muxpga_seq
//
// Self-checking bench for diferential_muxpga_seq. It contains a small
// behavioural fabric made of a 24-nibble shift chain and an io register.
// The io register evaluates to {nibble_in, nibble_in} only when every chain
// nibble holds the pass-through pattern, and to zero otherwise. While the
// fabric is shifting, its upper output nibble shows the chain tail, so
// recirculation preserves the configuration.
// ---------------------------------------------------------------------------
module tb_diferential_muxpga_seq;

  localparam int  NIB      = 24;
  localparam logic [3:0] CFG_PASS = 4'h6;
`ifdef DIFERENTIAL_SEQ_VERIFY_EN
  localparam int  EXP_SHIFTS = 2 * NIB;
`else
  localparam int  EXP_SHIFTS = NIB;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] run_len = 8'd0;
  logic [3:0] run_data = 4'h0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_nibble = 4'h0;
  logic       cfg_ready;
  logic       busy;
  logic       result_valid;
  logic [7:0] result;
  logic       result_ack = 1'b0;
  logic       err;
  logic       fpga_reset;
  logic [1:0] fpga_cmd;
  logic [3:0] fpga_nibble;
  logic [7:0] fpga_out;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  diferential_muxpga_seq #(.CFG_NIBBLES(24), .RUN_W(8), .CLEAR_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .run_len(run_len),
    .run_data(run_data), .cfg_valid(cfg_valid), .cfg_nibble(cfg_nibble),
    .cfg_ready(cfg_ready), .busy(busy), .result_valid(result_valid),
    .result(result), .result_ack(result_ack), .err(err),
    .fpga_reset(fpga_reset), .fpga_cmd(fpga_cmd), .fpga_nibble(fpga_nibble),
    .fpga_out(fpga_out)
  );

  // Behavioural fabric model
  logic [3:0] chain [NIB];
  logic [7:0] ioReg;
  logic       allPass;
  logic       corruptOn = 1'b0;

  always_comb begin
    allPass = 1'b1;
    for (int i = 0; i < NIB; i++) begin
      if (chain[i] != CFG_PASS) allPass = 1'b0;
    end
  end

  assign fpga_out = (fpga_cmd == 2'd0) ?
                    {chain[NIB-1] ^ (corruptOn ? 4'h1 : 4'h0), ioReg[3:0]} : ioReg;

  always @(posedge clk) begin
    if (fpga_reset) begin
      for (int i = 0; i < NIB; i++) chain[i] <= 4'h0;
      ioReg <= 8'h00;
    end else if (fpga_cmd == 2'd0) begin
      chain[0] <= fpga_nibble;
      for (int i = 1; i < NIB; i++) chain[i] <= chain[i-1];
    end else if (fpga_cmd == 2'd1) begin
      ioReg <= allPass ? {fpga_nibble, fpga_nibble} : 8'h00;
    end
  end

  // Pin activity counters; tests compare before/after differences
  int shiftCnt = 0;
  int evalCnt  = 0;
  int resetCnt = 0;
  int gapCnt   = 0;
  int badGap   = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (fpga_cmd == 2'd0) shiftCnt++;
      if (fpga_cmd == 2'd1) evalCnt++;
      if (fpga_reset) resetCnt++;
      if (cfg_ready && !cfg_valid && fpga_cmd == 2'd3) gapCnt++;
      if (cfg_ready && !cfg_valid && fpga_cmd != 2'd3) badGap++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Stimulus helpers (drive only)
  task automatic startJob(input logic [7:0] len, input logic [3:0] data);
    @(posedge clk); #1;
    start = 1'b1; run_len = len; run_data = data;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic loadCfg(input bit toggle, output int sent);
    int cyc;
    sent = 0;
    cyc = 0;
    while (sent < NIB && cyc < 300) begin
      @(posedge clk); #1;
      cfg_valid  = toggle ? cyc[0] : 1'b1;
      cfg_nibble = CFG_PASS;
      @(negedge clk);
      if (cfg_valid && cfg_ready) sent++;
      cyc++;
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (result_valid) ok = 1'b1;
    end
  endtask

  task automatic ackResult;
    @(posedge clk); #1;
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
    @(negedge clk);
  endtask

  // Tests
  task automatic test_reset;
    start = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    testsRun++;
    if (fpga_reset !== 1'b1 || fpga_cmd !== 2'd3 || fpga_nibble !== 4'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_fabric_pins got rst=%b cmd=%0d nib=%h want rst=1 cmd=3 nib=0",
               fpga_reset, fpga_cmd, fpga_nibble);
    end
    testsRun++;
    if (busy !== 1'b0 || cfg_ready !== 1'b0 || result_valid !== 1'b0 ||
        result !== 8'h00 || err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_host_pins got busy=%b rdy=%b rv=%b res=%h err=%b want all 0",
               busy, cfg_ready, result_valid, result, err);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0 || fpga_reset !== 1'b0 || fpga_cmd !== 2'd3) begin
      testsFailed++;
      $display("[TB] FAIL after_release got busy=%b rst=%b cmd=%0d want busy=0 rst=0 cmd=3",
               busy, fpga_reset, fpga_cmd);
    end
  endtask

  task automatic test_basic_job;
    int s0, e0, r0, sent;
    bit ok;
    s0 = shiftCnt; e0 = evalCnt; r0 = resetCnt;
    startJob(8'd3, 4'hA);
    loadCfg(1'b0, sent);
    testsRun++;
    if (sent !== NIB) begin
      testsFailed++;
      $display("[TB] FAIL basic_load_sent got %0d want %0d", sent, NIB);
    end
    waitDone(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL basic_done_timeout got no result_valid want result_valid=1");
    end
    testsRun++;
    if (result !== 8'hAA) begin
      testsFailed++;
      $display("[TB] FAIL basic_result got %h want aa", result);
    end
    testsRun++;
    if (resetCnt - r0 !== 2) begin
      testsFailed++;
      $display("[TB] FAIL basic_clear_cycles got %0d want 2", resetCnt - r0);
    end
    testsRun++;
    if (shiftCnt - s0 !== EXP_SHIFTS) begin
      testsFailed++;
      $display("[TB] FAIL basic_shift_count got %0d want %0d", shiftCnt - s0, EXP_SHIFTS);
    end
    testsRun++;
    if (evalCnt - e0 !== 4) begin
      testsFailed++;
      $display("[TB] FAIL basic_eval_count got %0d want 4", evalCnt - e0);
    end
    testsRun++;
    if (err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL basic_err got %b want 0", err);
    end
    repeat (3) @(negedge clk);
    testsRun++;
    if (result_valid !== 1'b1 || busy !== 1'b1 || fpga_cmd !== 2'd3) begin
      testsFailed++;
      $display("[TB] FAIL basic_hold got rv=%b busy=%b cmd=%0d want rv=1 busy=1 cmd=3",
               result_valid, busy, fpga_cmd);
    end
    ackResult();
    testsRun++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 8'hAA) begin
      testsFailed++;
      $display("[TB] FAIL basic_ack got rv=%b busy=%b res=%h want rv=0 busy=0 res=aa",
               result_valid, busy, result);
    end
  endtask

  task automatic test_stalled_load;
    int s0, g0, b0, sent;
    bit ok;
    s0 = shiftCnt; g0 = gapCnt; b0 = badGap;
    startJob(8'd3, 4'hA);
    loadCfg(1'b1, sent);
    waitDone(ok);
    testsRun++;
    if (!ok || result !== 8'hAA) begin
      testsFailed++;
      $display("[TB] FAIL stall_result got ok=%b res=%h want ok=1 res=aa", ok, result);
    end
    testsRun++;
    if (shiftCnt - s0 !== EXP_SHIFTS) begin
      testsFailed++;
      $display("[TB] FAIL stall_shift_count got %0d want %0d", shiftCnt - s0, EXP_SHIFTS);
    end
    testsRun++;
    if (badGap - b0 !== 0 || gapCnt - g0 < 20) begin
      testsFailed++;
      $display("[TB] FAIL stall_gaps got bad=%0d holds=%0d want bad=0 holds>=20",
               badGap - b0, gapCnt - g0);
    end
    ackResult();
  endtask

  task automatic test_zero_run;
    int s0, e0, sent;
    bit ok;
    s0 = shiftCnt; e0 = evalCnt;
    startJob(8'd0, 4'h5);
    loadCfg(1'b0, sent);
    waitDone(ok);
    testsRun++;
    if (!ok || result !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL zero_result got ok=%b res=%h want ok=1 res=00", ok, result);
    end
    testsRun++;
    if (evalCnt - e0 !== 1 || shiftCnt - s0 !== EXP_SHIFTS) begin
      testsFailed++;
      $display("[TB] FAIL zero_counts got evals=%0d shifts=%0d want evals=1 shifts=%0d",
               evalCnt - e0, shiftCnt - s0, EXP_SHIFTS);
    end
    ackResult();
  endtask

  task automatic test_ignored_inputs;
    int s0, e0, r0, sent;
    bit ok;
    s0 = shiftCnt; e0 = evalCnt; r0 = resetCnt;
    startJob(8'd5, 4'h3);
    start = 1'b1;
    loadCfg(1'b0, sent);
    start = 1'b0;
    cfg_valid = 1'b1;
    waitDone(ok);
    testsRun++;
    if (!ok || result !== 8'h33) begin
      testsFailed++;
      $display("[TB] FAIL ignore_result got ok=%b res=%h want ok=1 res=33", ok, result);
    end
    testsRun++;
    if (shiftCnt - s0 !== EXP_SHIFTS || evalCnt - e0 !== 6 || resetCnt - r0 !== 2) begin
      testsFailed++;
      $display("[TB] FAIL ignore_counts got shifts=%0d evals=%0d resets=%0d want %0d 6 2",
               shiftCnt - s0, evalCnt - e0, resetCnt - r0, EXP_SHIFTS);
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    testsRun++;
    if (result_valid !== 1'b1 || resetCnt - r0 !== 2) begin
      testsFailed++;
      $display("[TB] FAIL ignore_start_in_done got rv=%b resets=%0d want rv=1 resets=2",
               result_valid, resetCnt - r0);
    end
    @(posedge clk); #1;
    start = 1'b1; result_ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; result_ack = 1'b0; cfg_valid = 1'b0;
    repeat (4) @(negedge clk);
    testsRun++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || resetCnt - r0 !== 2) begin
      testsFailed++;
      $display("[TB] FAIL ack_and_start got busy=%b rv=%b resets=%0d want busy=0 rv=0 resets=2",
               busy, result_valid, resetCnt - r0);
    end
  endtask

`ifdef DIFERENTIAL_SEQ_VERIFY_EN
  task automatic test_verify_error;
    int sent;
    bit ok;
    startJob(8'd2, 4'h9);
    loadCfg(1'b0, sent);
    corruptOn = 1'b1;
    @(posedge clk); #1;
    corruptOn = 1'b0;
    waitDone(ok);
    testsRun++;
    if (!ok || err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL verify_err got ok=%b err=%b want ok=1 err=1", ok, err);
    end
    ackResult();
    testsRun++;
    if (err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL verify_err_sticky got %b want 1", err);
    end
    startJob(8'd1, 4'h4);
    @(negedge clk);
    testsRun++;
    if (err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL verify_err_clear got %b want 0", err);
    end
    loadCfg(1'b0, sent);
    waitDone(ok);
    testsRun++;
    if (!ok || err !== 1'b0 || result !== 8'h44) begin
      testsFailed++;
      $display("[TB] FAIL verify_clean got ok=%b err=%b res=%h want ok=1 err=0 res=44",
               ok, err, result);
    end
    ackResult();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_job();
    test_stalled_load();
    test_zero_run();
    test_ignored_inputs();
`ifdef DIFERENTIAL_SEQ_VERIFY_EN
    test_verify_error();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
